// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared state encoding, default widths and saturation limits
// Build option: PRODUCT_ACCUMULATOR_SATURATE_EN selects clamping instead of wrapping.
package product_acc_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DEFAULT_PROD_W = 64;
    localparam int DEFAULT_ACC_W  = 72;
    localparam int DEFAULT_CNT_W  = 8;

    // Saturation limits for the default accumulator width
    localparam logic [DEFAULT_ACC_W-1:0] ACC_MAX = {1'b0, {(DEFAULT_ACC_W-1){1'b1}}};
    localparam logic [DEFAULT_ACC_W-1:0] ACC_MIN = {1'b1, {(DEFAULT_ACC_W-1){1'b0}}};

endpackage

// File: rtl/product_acc_add.sv
// rtl/product_acc_add.sv - combinational sign-extend, add, overflow detect, optional clamp
// Ports: acc (current accumulator), product (signed product), sum (next accumulator),
//        ovf (signed overflow of this add).
// Build option: PRODUCT_ACCUMULATOR_SATURATE_EN clamps sum on overflow.
module product_acc_add
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEFAULT_PROD_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
        end else begin : g_noext
            assign ext = product;
        end
    endgenerate

    assign raw = acc + ext;

    // Overflow only possible when both operands share a sign and the result flips it
    assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow the operand sign tells the direction: negative operands overflowed low
    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - batch accumulator of signed products with valid/ready handshakes
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_product/in_last (product stream);
//        out_valid/out_ready/out_sum/out_count/out_ovf (batch result).
// Build option: PRODUCT_ACCUMULATOR_SATURATE_EN clamps the accumulator on overflow.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEFAULT_PROD_W,
    parameter int ACC_W  = DEFAULT_ACC_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             consume;

    product_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc     (acc),
        .product (in_product),
        .sum     (add_sum),
        .ovf     (add_ovf)
    );

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_ACCUM: if (accept && in_last) state_nx = ST_HOLD;
            ST_HOLD:  if (out_ready)         state_nx = ST_ACCUM;
            default:                         state_nx = ST_ACCUM;
        endcase
    end

    // Handshake signals depend on state only, never combinationally on the inputs
    always_comb begin
        in_ready  = (state == ST_ACCUM);
        out_valid = (state == ST_HOLD);
        out_sum   = acc;
        out_count = count;
        out_ovf   = ovf;
    end

    always_ff @(posedge clk) begin
        if (rst || consume) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= add_sum;
            ovf <= ovf | add_ovf;
            if (count != {CNT_W{1'b1}}) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator at two widths
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [63:0] in_product = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [71:0] out_sum_b;
    logic [7:0]  out_count_b;

    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [63:0] out_sum_s;
    logic [1:0]  out_count_s;

    always #5 clk = ~clk;

    product_accumulator u_big (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_product(in_product), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
    );

    product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_product(in_product), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_sum(out_sum_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
    );

    typedef struct {
        logic [127:0] sum;
        int           cnt;
        bit           ovf;
    } res_t;

    res_t q_big[$];
    res_t q_small[$];

    int vectors = 0;
    int miscompares = 0;

    logic signed [127:0] acc_big = '0;
    logic signed [127:0] acc_small = '0;
    bit ovf_big = 1'b0;
    bit ovf_small = 1'b0;
    int n_acc = 0;
    bit force_low = 1'b0;
    bit prev_hs = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Exact-integer reference: add, then fold the result back into a w-bit signed range
    function automatic void acc_step(inout logic signed [127:0] acc, inout bit o,
                                     input logic signed [127:0] p, input int w);
        logic signed [127:0] span, hi, lo, nv;
        span = 128'sd1 <<< w;
        hi   = (span >>> 1) - 128'sd1;
        lo   = -(span >>> 1);
        nv   = acc + p;
        if (nv > hi || nv < lo) begin
            o = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            acc = (nv > hi) ? hi : lo;
`else
            acc = (nv > hi) ? nv - span : nv + span;
`endif
        end else begin
            acc = nv;
        end
    endfunction

    function automatic void model_clear();
        acc_big = '0;
        acc_small = '0;
        ovf_big = 1'b0;
        ovf_small = 1'b0;
        n_acc = 0;
    endfunction

    function automatic void model_accept(input logic [63:0] p, input bit last);
        logic signed [127:0] pe;
        res_t rb, rs;
        pe = {{64{p[63]}}, p};
        acc_step(acc_big, ovf_big, pe, 72);
        acc_step(acc_small, ovf_small, pe, 64);
        n_acc++;
        if (last) begin
            rb.sum = acc_big;
            rb.cnt = (n_acc > 255) ? 255 : n_acc;
            rb.ovf = ovf_big;
            rs.sum = acc_small;
            rs.cnt = (n_acc > 3) ? 3 : n_acc;
            rs.ovf = ovf_small;
            q_big.push_back(rb);
            q_small.push_back(rs);
            model_clear();
        end
    endfunction

    // out_ready: random unless held low by a directed test
    always @(posedge clk) begin
        #1;
        out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: a result is consumed at the edge following a negedge with valid && ready
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                check("in_ready_after_result", {127'd0, in_ready_b}, 128'd1);
            end
            prev_hs = out_valid_b && out_ready;
            if (out_valid_b && out_ready) begin
                if (q_big.size() == 0) begin
                    fail_now("big_unexpected_result");
                end else begin
                    e = q_big.pop_front();
                    check("big_sum", {56'd0, out_sum_b}, {56'd0, e.sum[71:0]});
                    check("big_count", {120'd0, out_count_b}, 128'(e.cnt));
                    check("big_ovf", {127'd0, out_ovf_b}, {127'd0, e.ovf});
                end
            end
            if (out_valid_s && out_ready) begin
                if (q_small.size() == 0) begin
                    fail_now("small_unexpected_result");
                end else begin
                    e = q_small.pop_front();
                    check("small_sum", {64'd0, out_sum_s}, {64'd0, e.sum[63:0]});
                    check("small_count", {126'd0, out_count_s}, 128'(e.cnt));
                    check("small_ovf", {127'd0, out_ovf_s}, {127'd0, e.ovf});
                end
            end
        end
    end

    task automatic push(input logic [63:0] p, input bit last);
        bit hs;
        hs = 1'b0;
        in_valid = 1'b1;
        in_product = p;
        in_last = last;
        for (int i = 0; i < 1000 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready_b;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!hs) begin
            fail_now("push_timeout");
        end else begin
            model_accept(p, last);
            if (last) begin
                @(negedge clk);
                check("out_valid_after_last", {127'd0, out_valid_b}, 128'd1);
                check("in_ready_in_hold", {127'd0, in_ready_b}, 128'd0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_batch(input logic [63:0] ps[$]);
        for (int i = 0; i < ps.size(); i++) begin
            push(ps[i], i == ps.size() - 1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((q_big.size() != 0 || q_small.size() != 0) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q_big.size() != 0 || q_small.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        q_big.delete();
        q_small.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [63:0] rand_product();
        logic [63:0] v;
        case ($urandom_range(0, 4))
            0: v = 64'h7FFF_FFFF_FFFF_FFFF;
            1: v = 64'h8000_0000_0000_0000;
            2: v = {$urandom(), $urandom()};
            default: v = 64'($signed($urandom_range(0, 2000)) - 1000);
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] b[$];
        logic [71:0] neg5;
        neg5 = -72'sd5;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {127'd0, in_ready_b}, 128'd1);
        check("reset_out_valid", {127'd0, out_valid_b}, 128'd0);
        check("reset_sum", {56'd0, out_sum_b}, 128'd0);
        check("reset_count", {120'd0, out_count_b}, 128'd0);
        check("reset_ovf", {127'd0, out_ovf_b}, 128'd0);
        @(posedge clk);
        #1;

        b = '{-64'sd25, 64'sd25, 64'sd25, -64'sd25};
        run_batch(b);
        b = '{64'sd48, -64'sd72};
        run_batch(b);
        wait_drain(200);

        // Result held while out_ready is low; a waiting product must stay stalled
        @(negedge clk);
        force_low = 1'b1;
        @(posedge clk);
        #1;
        push(-64'sd5, 1'b1);
        fork
            push(64'd777, 1'b1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("hold_valid", {127'd0, out_valid_b}, 128'd1);
                    check("hold_sum", {56'd0, out_sum_b}, {56'd0, neg5});
                    check("hold_count", {120'd0, out_count_b}, 128'd1);
                    check("hold_in_ready", {127'd0, in_ready_b}, 128'd0);
                end
                force_low = 1'b0;
            end
        join

        b = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
        run_batch(b);

        // Abort a batch mid-way; nothing from it may appear
        wait_drain(200);
        push(64'd8, 1'b0);
        push(64'd6, 1'b0);
        do_reset();
        push(64'd5, 1'b1);

        b = '{64'd1, 64'd1, 64'd1, 64'd1, 64'd1};
        run_batch(b);

        // Long batch: count saturates and the 72-bit accumulator overflows
        b.delete();
        for (int i = 0; i < 260; i++) b.push_back(64'h7FFF_FFFF_FFFF_FFFF);
        run_batch(b);

        // Reset while a result is pending discards it
        wait_drain(200);
        @(negedge clk);
        force_low = 1'b1;
        @(posedge clk);
        #1;
        push(64'd3, 1'b1);
        do_reset();
        @(negedge clk);
        check("reset_in_hold_valid", {127'd0, out_valid_b}, 128'd0);
        check("reset_in_hold_sum", {56'd0, out_sum_b}, 128'd0);
        force_low = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            b.delete();
            for (int i = 0; i < $urandom_range(1, 8); i++) b.push_back(rand_product());
            run_batch(b);
        end

        wait_drain(500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 32x32 signed shift multiplier.
- Consumes its 64-bit signed products and sums them into a wide signed accumulator.
- Uses a valid/ready handshake on both sides.
- On a tagged last product, presents the final sum, product count and overflow flag, then clears for the next batch.

Parameters:
- PROD_W, 64, signed product width from the multiplier
- ACC_W, 72, accumulator width (8 guard bits); must be >= PROD_W
- CNT_W, 8, product counter width

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  product present
- in_ready  output  1  block can accept a product
- in_product  input  PROD_W  signed product
- in_last  input  1  marks the final product of a batch; qualified by the in_valid && in_ready handshake
- out_valid  output  1  batch result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  signed batch sum
- out_count  output  CNT_W  number of products accepted in the batch
- out_ovf  output  1  sticky: signed overflow occurred during the batch

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge, including mid-batch or with out_valid high): state=ACCUM, acc=0, count=0, ovf=0, out_valid=0. A pending result is discarded.
- in_ready is derived from state only: 1 in ACCUM, 0 in HOLD. It never depends combinationally on in_valid.
- States:
  - ACCUM: on in_valid&&in_ready:
    - acc <= acc + sign-extended in_product (ACC_W bits).
    - count <= count+1, saturating at 2^CNT_W-1.
    - ovf |= signed overflow of that add (operand signs equal, result sign differs).
    - If in_last, go to HOLD.
  - HOLD: out_valid=1; out_sum/out_count/out_ovf are the registered acc/count/ovf and stay stable.
    - On out_ready: acc, count and ovf clear to 0; go to ACCUM.
- Latency: out_valid rises the cycle after the last product is accepted. out_sum includes that last product.
- Throughput: one product per cycle in ACCUM. One bubble cycle per batch, because in_ready=0 throughout HOLD, including the handshake cycle.
- Overflow: without saturation, acc wraps modulo 2^ACC_W. ovf stays set until the result is consumed or rst.
- Single-product batch (in_last on first accept): out_sum = sign-extended product, out_count=1.
- in_valid=0 in ACCUM: no state change. Products arriving during HOLD are stalled by in_ready=0.
- Outputs in ACCUM: out_sum/out_count/out_ovf reflect the live registers; they are don't-care to the consumer.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: on signed overflow, acc clamps to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow) instead of wrapping. ovf is still set. Further adds continue from the clamped value.
- Undefined: two's-complement wrap; ovf set as above.

Decomposition:
- Shared package product_acc_pkg holds:
  - state encoding (ST_ACCUM, ST_HOLD)
  - default widths (PROD_W, ACC_W, CNT_W)
  - ACC_MAX/ACC_MIN constants used for saturation
- One natural sub-module: product_acc_add. It is combinational: sign-extend, add, overflow detect, optional clamp. It returns {sum, ovf}.

Test Plan:
- Batch of -25, 25, 25, -25 (last on 4th), out_ready=1 → out_valid one cycle after 4th accept; out_sum=0, out_count=4, out_ovf=0; in_ready back to 1 the cycle after.
- Batch of 48, -72 → out_sum=-24 (72-bit 0xFF...FFE8), out_count=2.
- Single product -5 with in_last, out_ready held 0 for 5 cycles → out_valid=1, out_sum=-5, count=1, in_ready=0 and outputs stable all 5 cycles; the in_valid=1 stimulus is stalled and not accumulated.
- ACC_W=64: products 0x7FFF_FFFF_FFFF_FFFF then 1 (last) →
  - without macro: out_sum=0x8000_0000_0000_0000, out_ovf=1;
  - with PRODUCT_ACCUMULATOR_SATURATE_EN: out_sum=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Two products 8, 6 accepted, then rst=1 for one cycle, then batch {5 last} → out_sum=5, out_count=1, out_ovf=0; no result emitted for the aborted batch.
- CNT_W=2: five products of 1 with last on 5th → out_sum=5, out_count=3 (saturated).
